// File: rtl/fp_mul4_seq.sv
// rtl/fp_mul4_seq.sv - a*b*c*d over one shared fp32 multiplier in three steps.
// Optional FP_SEQ_EARLY_ABORT_EN: finish early when a step raises mul_exception.
module fp_mul4_seq #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic [31:0] c_operand,
  input  logic [31:0] d_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  input  logic        mul_exception,
  input  logic        mul_overflow,
  input  logic        mul_underflow
);

  typedef enum logic [2:0] {IDLE, STEP1, STEP2, STEP3, DONE} state_t;

  localparam logic [2:0] LAT = 3'(MUL_LAT);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] b_q, b_d, c_q, c_d, d_q, d_d;
  logic [31:0] result_q, result_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        abort;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    result_d    = result_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    cnt_d       = cnt_q;
    exc_d       = exc_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef FP_SEQ_EARLY_ABORT_EN
    abort = mul_exception;
`else
    abort = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = STEP1;
          acc_d      = a_operand;
          b_d        = b_operand;
          c_d        = c_operand;
          d_d        = d_operand;
          cnt_d      = '0;
          exc_d      = 1'b0;
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          // Operands go straight out so the first step sees them on its first cycle.
          mul_a_d    = a_operand;
          mul_b_d    = b_operand;
        end
      end

      STEP1, STEP2, STEP3: begin
        if (cnt_q != LAT) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          cnt_d = '0;
          acc_d = mul_result;
          exc_d = exc_q | mul_exception;
          ovf_d = ovf_q | mul_overflow;
          unf_d = unf_q | mul_underflow;
          if (state_q == STEP3 || abort) begin
            state_d     = DONE;
            result_d    = mul_result;
            out_valid_d = 1'b1;
            mul_a_d     = '0;
            mul_b_d     = '0;
          end else begin
            state_d = (state_q == STEP1) ? STEP2 : STEP3;
            mul_a_d = mul_result;
            mul_b_d = (state_q == STEP1) ? c_q : d_q;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
        mul_a_d     = '0;
        mul_b_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      result_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      cnt_q       <= '0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      result_q    <= result_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      cnt_q       <= cnt_d;
      exc_q       <= exc_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign Exception = exc_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule
